// File: rtl/uart_frame.sv
// uart_frame: UART with runtime parity/stop selection and valid/ready byte ports.
// Optional feature: define UART_RX_SYNC_EN to pass rx through a two-flop synchroniser.
module uart_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DIV_W-1:0]     baud,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 brk,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 is_receiving,
  output logic                 is_transmitting
);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [DIV_W-1:0] baud_eff;
  assign baud_eff = (baud == '0) ? DIV_W'(1) : baud;

  logic rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_reg;
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rx};
  end
  assign rx_s = sync_reg[1];
`else
  assign rx_s = rx;
`endif

  tx_state_t              tx_state_reg, tx_state_next;
  logic [DIV_W-1:0]       tx_cnt_reg, tx_cnt_next;
  logic [OS_W-1:0]        tx_os_reg, tx_os_next;
  logic [BIT_W-1:0]       tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0]   tx_data_reg, tx_data_next;
  logic                   tx_pen_reg, tx_pen_next, tx_podd_reg, tx_podd_next;
  logic                   tx_two_reg, tx_two_next, tx_reg, tx_line_next, tx_restart, tx_tick;

  assign tx_tick = (tx_cnt_reg == DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= baud_eff;
      tx_os_reg    <= '0;
      tx_bit_reg   <= '0;
      tx_data_reg  <= '0;
      tx_pen_reg   <= 1'b0;
      tx_podd_reg  <= 1'b0;
      tx_two_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_os_reg    <= tx_os_next;
      tx_bit_reg   <= tx_bit_next;
      tx_data_reg  <= tx_data_next;
      tx_pen_reg   <= tx_pen_next;
      tx_podd_reg  <= tx_podd_next;
      tx_two_reg   <= tx_two_next;
      tx_reg       <= tx_line_next & ~brk;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_os_next    = tx_os_reg;
    tx_bit_next   = tx_bit_reg;
    tx_data_next  = tx_data_reg;
    tx_pen_next   = tx_pen_reg;
    tx_podd_next  = tx_podd_reg;
    tx_two_next   = tx_two_reg;
    tx_restart    = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_data_next  = tx_data;
          tx_pen_next   = parity_en;
          tx_podd_next  = parity_odd;
          tx_two_next   = two_stop;
          tx_os_next    = '0;
          tx_bit_next   = '0;
          tx_restart    = 1'b1;
          tx_state_next = TX_START;
        end
      end
      default: begin
        if (tx_tick) begin
          if (tx_os_reg == OS_LAST) begin
            tx_os_next = '0;
            case (tx_state_reg)
              TX_START: tx_state_next = TX_DATA;
              TX_DATA: begin
                if (tx_bit_reg == BIT_LAST) begin
                  tx_bit_next   = '0;
                  tx_state_next = tx_pen_reg ? TX_PARITY : TX_STOP;
                end else begin
                  tx_bit_next = tx_bit_reg + 1'b1;
                end
              end
              TX_PARITY: tx_state_next = TX_STOP;
              TX_STOP: begin
                // tx_bit_reg doubles as the stop-bit counter
                if (tx_two_reg && tx_bit_reg == '0) tx_bit_next = BIT_W'(1);
                else                                 tx_state_next = TX_IDLE;
              end
              default: tx_state_next = TX_IDLE;
            endcase
          end else begin
            tx_os_next = tx_os_reg + 1'b1;
          end
        end
      end
    endcase
    tx_cnt_next = (tx_restart || tx_tick) ? baud_eff : tx_cnt_reg - 1'b1;
  end

  // Line level is derived from the next state so tx changes on the handshake edge
  always_comb begin
    tx_ready        = (tx_state_reg == TX_IDLE);
    is_transmitting = (tx_state_reg != TX_IDLE);
    case (tx_state_next)
      TX_START:  tx_line_next = 1'b0;
      TX_DATA:   tx_line_next = tx_data_next[tx_bit_next];
      TX_PARITY: tx_line_next = (^tx_data_next) ^ tx_podd_next;
      default:   tx_line_next = 1'b1;
    endcase
  end

  assign tx = tx_reg;

  rx_state_t              rx_state_reg, rx_state_next;
  logic [DIV_W-1:0]       rx_cnt_reg, rx_cnt_next;
  logic [OS_W-1:0]        rx_os_reg, rx_os_next;
  logic [BIT_W-1:0]       rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next, rx_data_reg, rx_data_next;
  logic                   rx_pen_reg, rx_pen_next, rx_podd_reg, rx_podd_next, rx_perr_reg, rx_perr_next;
  logic                   rx_valid_reg, rx_valid_next, rx_parity_err_reg, rx_parity_err_next;
  logic                   rx_frame_err_reg, rx_frame_err_next, rx_overrun_reg, rx_overrun_next;
  logic                   rx_restart, rx_deliver, rx_tick;

  assign rx_tick = (rx_cnt_reg == DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg      <= RX_IDLE;
      rx_cnt_reg        <= baud_eff;
      rx_os_reg         <= '0;
      rx_bit_reg        <= '0;
      rx_shift_reg      <= '0;
      rx_pen_reg        <= 1'b0;
      rx_podd_reg       <= 1'b0;
      rx_perr_reg       <= 1'b0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
      rx_overrun_reg    <= 1'b0;
    end else begin
      rx_state_reg      <= rx_state_next;
      rx_cnt_reg        <= rx_cnt_next;
      rx_os_reg         <= rx_os_next;
      rx_bit_reg        <= rx_bit_next;
      rx_shift_reg      <= rx_shift_next;
      rx_pen_reg        <= rx_pen_next;
      rx_podd_reg       <= rx_podd_next;
      rx_perr_reg       <= rx_perr_next;
      rx_data_reg       <= rx_data_next;
      rx_valid_reg      <= rx_valid_next;
      rx_parity_err_reg <= rx_parity_err_next;
      rx_frame_err_reg  <= rx_frame_err_next;
      rx_overrun_reg    <= rx_overrun_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_os_next    = rx_os_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_pen_next   = rx_pen_reg;
    rx_podd_next  = rx_podd_reg;
    rx_perr_next  = rx_perr_reg;
    rx_restart    = 1'b0;
    rx_deliver    = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_restart    = 1'b1;
          rx_os_next    = '0;
          rx_pen_next   = parity_en;
          rx_podd_next  = parity_odd;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_os_reg == OS_MID) begin
            rx_os_next    = '0;
            rx_bit_next   = '0;
            rx_perr_next  = 1'b0;
            rx_state_next = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_os_next = rx_os_reg + 1'b1;
          end
        end
      end
      RX_DATA, RX_PARITY, RX_STOP: begin
        if (rx_tick) begin
          if (rx_os_reg == OS_LAST) begin
            rx_os_next = '0;
            if (rx_state_reg == RX_DATA) begin
              rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
              if (rx_bit_reg == BIT_LAST) rx_state_next = rx_pen_reg ? RX_PARITY : RX_STOP;
              else                        rx_bit_next   = rx_bit_reg + 1'b1;
            end else if (rx_state_reg == RX_PARITY) begin
              rx_perr_next  = rx_s ^ (^rx_shift_reg) ^ rx_podd_reg;
              rx_state_next = RX_STOP;
            end else begin
              rx_deliver    = 1'b1;
              rx_state_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
          end else begin
            rx_os_next = rx_os_reg + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_next = RX_IDLE;
      default:      rx_state_next = RX_IDLE;
    endcase
    rx_cnt_next = (rx_restart || rx_tick) ? baud_eff : rx_cnt_reg - 1'b1;
  end

  // A read in the delivery cycle frees the slot, so the new byte is accepted
  always_comb begin
    rx_data_next       = rx_data_reg;
    rx_valid_next      = rx_valid_reg;
    rx_parity_err_next = rx_parity_err_reg;
    rx_frame_err_next  = rx_frame_err_reg;
    rx_overrun_next    = rx_overrun_reg;
    if (rx_deliver) begin
      if (!rx_valid_reg || rx_ready) begin
        rx_data_next       = rx_shift_reg;
        rx_parity_err_next = rx_pen_reg & rx_perr_reg;
        rx_frame_err_next  = ~rx_s;
        rx_valid_next      = 1'b1;
        rx_overrun_next    = 1'b0;
      end else begin
        rx_overrun_next = 1'b1;
      end
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_next      = 1'b0;
      rx_parity_err_next = 1'b0;
      rx_frame_err_next  = 1'b0;
      rx_overrun_next    = 1'b0;
    end
    is_receiving = (rx_state_reg != RX_IDLE);
  end

  assign rx_valid      = rx_valid_reg;
  assign rx_data       = rx_data_reg;
  assign rx_parity_err = rx_parity_err_reg;
  assign rx_frame_err  = rx_frame_err_reg;
  assign rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_frame.sv
// Bench for uart_frame: frames are modelled as bit lists built from the framing rules,
// then compared cycle by cycle on tx, or driven onto rx and checked at the byte port.
module tb_uart_frame;
  localparam int D  = 8;
  localparam int OS = 4;

  logic        clk = 1'b0, rst = 1'b1, rx_drv = 1'b1, loop = 1'b0;
  logic        rx_w, tx;
  logic [15:0] baud = 16'd4;
  logic        parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0, brk = 1'b0;
  logic        tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, rx_valid, rx_parity_err, rx_frame_err, rx_overrun;
  logic        is_receiving, is_transmitting;
  logic [7:0]  rx_data;
  int          tests = 0, fails = 0;

  assign rx_w = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_frame #(.DATA_BITS(D), .OVERSAMPLE(OS), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx_w), .tx(tx), .baud(baud),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop), .brk(brk),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .is_receiving(is_receiving), .is_transmitting(is_transmitting)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit exp_par(input logic [7:0] d, input bit odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  function automatic int bitlen();
    return ((baud == 16'd0) ? 1 : int'(baud)) * OS;
  endfunction

  // Sends one byte and checks every cycle of the tx line against the modelled frame.
  task automatic tx_frame(input logic [7:0] d, input bit scramble);
    bit q[$];
    bit pe, po, ts;
    int bl, n;
    pe = parity_en; po = parity_odd; ts = two_stop; bl = bitlen();
    q.push_back(1'b0);
    for (int i = 0; i < D; i++) q.push_back(d[i]);
    if (pe) q.push_back(exp_par(d, po));
    q.push_back(1'b1);
    if (ts) q.push_back(1'b1);
    n = q.size() * bl;
    check("tx_ready_idle", 32'(tx_ready), 32'd1);
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("tx_line", 32'(tx), 32'(q[k / bl]));
      check("tx_busy", 32'(tx_ready), 32'd0);
      if (scramble && k == bl + 3) begin
        parity_en = ~pe; parity_odd = ~po; two_stop = ~ts;
      end
    end
    @(negedge clk);
    check("tx_ready_end", 32'(tx_ready), 32'd1);
    check("tx_idle_line", 32'(tx), 32'd1);
    parity_en = pe; parity_odd = po; two_stop = ts;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit pe, input bit po, input bit flip,
                             input int stop_low);
    bit q[$];
    int bl;
    bl = bitlen();
    q.push_back(1'b0);
    for (int i = 0; i < D; i++) q.push_back(d[i]);
    if (pe) q.push_back(exp_par(d, po) ^ flip);
    if (stop_low > 0) for (int i = 0; i < stop_low; i++) q.push_back(1'b0);
    else q.push_back(1'b1);
    foreach (q[i]) begin
      rx_drv = q[i];
      repeat (bl) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_rx(input logic [7:0] d, input bit perr, input bit ferr, input bit ovr);
    @(negedge clk);
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(d));
    check("rx_parity_err", 32'(rx_parity_err), 32'(perr));
    check("rx_frame_err", 32'(rx_frame_err), 32'(ferr));
    check("rx_overrun", 32'(rx_overrun), 32'(ovr));
    @(posedge clk); #1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("rx_consumed", 32'(rx_valid), 32'd0);
    check("rx_flags_clr", 32'({rx_overrun, rx_parity_err, rx_frame_err}), 32'd0);
    @(posedge clk); #1;
  endtask

  // rx_ready is pulsed exactly on the edge that samples the stop bit mid-bit
  task automatic simul_deliver(input logic [7:0] d);
    int off, zeros;
    off = 1 + (bitlen() / OS) * (OS / 2 + OS * (D + 1));
    zeros = 0;
    fork
      drive_frame(d, 1'b0, 1'b0, 1'b0, 0);
      begin
        repeat (off - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
      end
      begin
        for (int k = 0; k < off + 2; k++) begin
          @(negedge clk);
          if (rx_valid !== 1'b1) zeros++;
        end
      end
    join
    check("rx_valid_held", 32'(zeros), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb [3];
    logic [7:0] d;
    bit pe, po, fl;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
    check("rst_busy", 32'({is_receiving, is_transmitting}), 32'd0);
    @(posedge clk); #1;

    tx_frame(8'hA5, 1'b0);

    brk = 1'b1;
    @(posedge clk); @(negedge clk);
    check("brk_tx", 32'(tx), 32'd0);
    check("brk_fsm_idle", 32'({is_transmitting, tx_ready}), 32'd1);
    brk = 1'b0;
    @(posedge clk); @(negedge clk);
    check("brk_release", 32'(tx), 32'd1);
    @(posedge clk); #1;

    loop = 1'b1; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_frame(lb[i], 1'b0);
      check_rx(lb[i], 1'b0, 1'b0, 1'b0);
      consume();
    end
    loop = 1'b0; two_stop = 1'b0;

    parity_en = 1'b1; parity_odd = 1'b0;
    drive_frame(8'h41, 1'b1, 1'b0, 1'b1, 0);
    check_rx(8'h41, 1'b1, 1'b0, 1'b0);
    consume();

    parity_en = 1'b0;
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0, 3);
    @(negedge clk);
    check("wait_high_busy", 32'(is_receiving), 32'd1);
    @(negedge clk);
    check("wait_high_exit", 32'(is_receiving), 32'd0);
    check_rx(8'h5A, 1'b0, 1'b1, 1'b0);
    consume();

    drive_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(8'h22, 1'b0, 1'b0, 1'b0, 0);
    check_rx(8'h11, 1'b0, 1'b0, 1'b1);
    consume();

    drive_frame(8'h2C, 1'b0, 1'b0, 1'b0, 0);
    check_rx(8'h2C, 1'b0, 1'b0, 1'b0);
    simul_deliver(8'h33);
    check_rx(8'h33, 1'b0, 1'b0, 1'b0);
    consume();

    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    @(negedge clk);
    check("glitch_start", 32'(is_receiving), 32'd1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", 32'(is_receiving), 32'd0);
    check("glitch_no_byte", 32'(rx_valid), 32'd0);
    check("glitch_flags", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
    @(posedge clk); #1;

    rx_drv = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rx_partial_busy", 32'(is_receiving), 32'd1);
    rst = 1'b1; rx_drv = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rx_rst_idle", 32'(is_receiving), 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("rx_rst_dropped", 32'({rx_valid, rx_frame_err, rx_overrun}), 32'd0);
    @(posedge clk); #1;

    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (69) @(posedge clk);
    @(negedge clk);
    check("tx_bit3_low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("tx_rst_line", 32'(tx), 32'd1);
    check("tx_rst_ready", 32'(tx_ready), 32'd1);
    check("tx_rst_idle", 32'(is_transmitting), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      baud = 16'($urandom_range(0, 3));
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop = 1'($urandom_range(0, 1));
      tx_frame(8'($urandom), 1'($urandom_range(0, 1)));
    end

    loop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      baud = 16'($urandom_range(0, 3));
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      tx_frame(d, 1'b0);
      check_rx(d, 1'b0, 1'b0, 1'b0);
      consume();
    end
    loop = 1'b0; two_stop = 1'b0;

    for (int i = 0; i < 6; i++) begin
      baud = 16'($urandom_range(1, 4));
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      fl = pe & 1'($urandom_range(0, 1));
      d = 8'($urandom);
      parity_en = pe; parity_odd = po;
      drive_frame(d, pe, po, fl, 0);
      check_rx(d, fl, 1'b0, 1'b0);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
